// File: rtl/sdram_port_arbiter_pkg.sv
// Shared encodings for the SDRAM port arbiter: controller commands, FSM states
// and the default refresh period (package sdram_arb_defs).
package sdram_arb_defs;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_READ    = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // 7.8 us at 50 MHz
  localparam int DEF_REF_PERIOD = 390;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Command bus between the port arbiter (master) and the SDRAM command engine (slave).
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              ctl_valid;
  logic [1:0]        ctl_cmd;
  logic [ADDR_W-1:0] ctl_addr;
  logic              ctl_ready;
  logic              ctl_done;

  modport master (output ctl_valid, ctl_cmd, ctl_addr, input  ctl_ready, ctl_done);
  modport slave  (input  ctl_valid, ctl_cmd, ctl_addr, output ctl_ready, ctl_done);
endinterface

// File: rtl/sdram_port_arbiter_ref_timer.sv
// Auto-refresh timer: periodic refresh request, cleared by the arbiter's ack,
// with a sticky overrun flag when a period expires on an unserved request.
module sdram_ref_timer
  import sdram_arb_defs::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic clk50m,
  input  logic rst,
  input  logic ref_ack,
  output logic ref_pend,
  output logic ref_overrun
);
  localparam int               CNT_W  = $clog2(REF_PERIOD);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             expire;

  assign expire = (cnt_q == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d  = expire ? RELOAD : cnt_q - 1'b1;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (expire) begin
      pend_d = 1'b1;
      ovr_d  = ovr_q | pend_q;
    end else if (ref_ack) begin
      pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign ref_pend    = pend_q;
  assign ref_overrun = ovr_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter (refresh, video write, LCD read) issuing one burst at a time
// to the SDRAM controller. Optional WAIT_DONE watchdog under `ARB_WDOG_EN.
module sdram_port_arbiter
  import sdram_arb_defs::*;
#(
  parameter int ADDR_W     = 22,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int MAX_SKIP   = 4
) (
  input  logic                 clk50m,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  output logic                 wr_gnt,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_gnt,
  sdram_port_arbiter_if.master ctl,
  output logic                 busy,
`ifdef ARB_WDOG_EN
  output logic                 wdog_err,
`endif
  output logic                 ref_overrun
);
  localparam int                SKIP_W   = $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              xfer, ref_pend, ref_ack;

`ifdef ARB_WDOG_EN
  localparam logic [9:0] WDOG_CYC = 10'd1000;
  logic [9:0] wdog_cnt_q, wdog_cnt_d;
  logic       wdog_err_q, wdog_err_d;
`endif

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk50m      (clk50m),
    .rst         (rst),
    .ref_ack     (ref_ack),
    .ref_pend    (ref_pend),
    .ref_overrun (ref_overrun)
  );

  assign xfer          = (state_q == ST_ISSUE) & ctl.ctl_ready;
  assign ctl.ctl_valid = (state_q == ST_ISSUE);
  assign ctl.ctl_cmd   = ctl.ctl_valid ? cmd_q  : CMD_NOP;
  assign ctl.ctl_addr  = ctl.ctl_valid ? addr_q : '0;
  assign wr_gnt        = xfer & (cmd_q == CMD_WRITE);
  assign rd_gnt        = xfer & (cmd_q == CMD_READ);
  assign ref_ack       = xfer & (cmd_q == CMD_REFRESH);
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
`ifdef ARB_WDOG_EN
    wdog_cnt_d = (state_q == ST_WAIT_DONE) ? wdog_cnt_q + 1'b1 : '0;
    wdog_err_d = wdog_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ISSUE;
        if (ref_pend) begin
          cmd_d  = CMD_REFRESH;
          addr_d = '0;
        end else if (wr_req && skip_q == SKIP_MAX) begin
          cmd_d  = CMD_WRITE;
          addr_d = wr_addr;
        end else if (rd_req) begin
          cmd_d  = CMD_READ;
          addr_d = rd_addr;
        end else if (wr_req) begin
          cmd_d  = CMD_WRITE;
          addr_d = wr_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE:     if (ctl.ctl_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (ctl.ctl_done) state_d = ST_IDLE;
`ifdef ARB_WDOG_EN
        else if (wdog_cnt_q == WDOG_CYC - 10'd1) begin
          state_d    = ST_IDLE;
          wdog_err_d = 1'b1;
        end
`endif
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Reads starve a pending write at most MAX_SKIP times in a row.
  always_comb begin
    skip_d = skip_q;
    if (wr_gnt)                                skip_d = '0;
    else if (rd_gnt && wr_req && skip_q != SKIP_MAX) skip_d = skip_q + 1'b1;
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      skip_q  <= skip_d;
    end
  end

`ifdef ARB_WDOG_EN
  always_ff @(posedge clk50m) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end
  assign wdog_err = wdog_err_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected commands are queued when
// requests are raised and compared when the arbiter presents them to the controller.
module tb_sdram_port_arbiter;
  import sdram_arb_defs::*;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [21:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic [21:0] wr_addr, rd_addr;
  logic        wr_gnt, rd_gnt, busy, ref_overrun;
`ifdef ARB_WDOG_EN
  logic        wdog_err;
`endif
  int          cyc;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb_q[$];

  sdram_port_arbiter_if #(.ADDR_W(22)) ctl_if ();

  sdram_port_arbiter dut (
    .clk50m      (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .ctl         (ctl_if),
    .busy        (busy),
`ifdef ARB_WDOG_EN
    .wdog_err    (wdog_err),
`endif
    .ref_overrun (ref_overrun)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic apply_reset();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
    ctl_if.ctl_ready = 1'b0; ctl_if.ctl_done = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Controller model: wait for a command, stall ready, accept it.
  task automatic serve(input int rdy_wait, output logic [1:0] cmd, output logic [21:0] addr,
                       output logic wg, output logic rg, output bit ok, output bit stable,
                       output int vcyc);
    int n = 0;
    ok = 1'b0; stable = 1'b1; cmd = '0; addr = '0; wg = 1'b0; rg = 1'b0; vcyc = -1;
    while (ctl_if.ctl_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ctl_if.ctl_valid !== 1'b1) return;
    vcyc = cyc; cmd = ctl_if.ctl_cmd; addr = ctl_if.ctl_addr;
    for (int i = 0; i < rdy_wait; i++) begin
      if (ctl_if.ctl_cmd !== cmd || ctl_if.ctl_addr !== addr || ctl_if.ctl_valid !== 1'b1 ||
          wr_gnt !== 1'b0 || rd_gnt !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    ctl_if.ctl_ready = 1'b1;
    #1;
    wg = wr_gnt; rg = rd_gnt;
    if (ctl_if.ctl_cmd !== cmd || ctl_if.ctl_addr !== addr) stable = 1'b0;
    ok = 1'b1;
    @(negedge clk);
    ctl_if.ctl_ready = 1'b0;
  endtask

  task automatic finish_burst(input int d);
    repeat (d) @(negedge clk);
    ctl_if.ctl_done = 1'b1;
    @(negedge clk);
    ctl_if.ctl_done = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [27:0] got;
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_addr = 22'h3; rd_addr = 22'h5;
    ctl_if.ctl_ready = 1'b1; ctl_if.ctl_done = 1'b0;
    repeat (2) @(negedge clk);
    got = {ctl_if.ctl_valid, ctl_if.ctl_cmd, ctl_if.ctl_addr, wr_gnt, rd_gnt, busy, ref_overrun};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", got);
    end
  endtask

  task automatic test_refresh_period();
    logic [1:0] c; logic [21:0] a; logic wg, rg; bit ok, st; int v1, v2;
    apply_reset();
    serve(0, c, a, wg, rg, ok, st, v1);
    vectors++;
    if (!ok || c !== CMD_REFRESH || a !== '0 || wg || rg || v1 != 391) begin
      miscompares++;
      $display("FAIL refresh_first: ok=%0b cmd=%0d addr=%h gnt=%0b%0b cyc=%0d, want cmd=3 addr=0 gnt=00 cyc=391",
               ok, c, a, wg, rg, v1);
    end
    finish_burst(4);
    serve(0, c, a, wg, rg, ok, st, v2);
    vectors++;
    if (!ok || c !== CMD_REFRESH || v2 - v1 != 390) begin
      miscompares++;
      $display("FAIL refresh_period: ok=%0b cmd=%0d spacing=%0d, want cmd=3 spacing=390", ok, c, v2 - v1);
    end
    finish_burst(1);
    vectors++;
    if (ref_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL refresh_no_overrun: got %0b, want 0", ref_overrun);
    end
  endtask

  task automatic test_rd_wr_order();
    logic [1:0] c; logic [21:0] a; logic wg, rg; bit ok, st; int vc; exp_t e;
    apply_reset();
    wr_req = 1'b1; wr_addr = 22'h1A5A5; rd_req = 1'b1; rd_addr = 22'h2C3C3;
    sb_q.push_back('{CMD_READ, 22'h2C3C3});
    sb_q.push_back('{CMD_WRITE, 22'h1A5A5});
    for (int k = 0; k < 2; k++) begin
      serve(0, c, a, wg, rg, ok, st, vc);
      e = sb_q.pop_front();
      vectors++;
      if (!ok || c !== e.cmd || a !== e.addr || wg !== (e.cmd == CMD_WRITE) || rg !== (e.cmd == CMD_READ)) begin
        miscompares++;
        $display("FAIL rd_wr_order[%0d]: ok=%0b cmd=%0d addr=%h wg=%0b rg=%0b, want cmd=%0d addr=%h",
                 k, ok, c, a, wg, rg, e.cmd, e.addr);
      end
      if (rg) rd_req = 1'b0;
      if (wg) wr_req = 1'b0;
      vectors++;
      if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL gnt_single_pulse[%0d]: wg=%0b rg=%0b busy=%0b, want 0 0 1", k, wr_gnt, rd_gnt, busy);
      end
      finish_burst(2);
    end
  endtask

  task automatic test_skip_fairness();
    logic [1:0] c; logic [21:0] a; logic wg, rg; bit ok, st; int vc; exp_t e;
    apply_reset();
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 22'($urandom); rd_addr = 22'($urandom);
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) sb_q.push_back('{CMD_WRITE, wr_addr});
      else            sb_q.push_back('{CMD_READ, rd_addr});
      serve(0, c, a, wg, rg, ok, st, vc);
      e = sb_q.pop_front();
      vectors++;
      if (!ok || c !== e.cmd || a !== e.addr || wg !== (e.cmd == CMD_WRITE) || rg !== (e.cmd == CMD_READ)) begin
        miscompares++;
        $display("FAIL skip_pattern[%0d]: ok=%0b cmd=%0d addr=%h wg=%0b rg=%0b, want cmd=%0d addr=%h",
                 k, ok, c, a, wg, rg, e.cmd, e.addr);
      end
      if (rg) rd_addr = 22'($urandom);
      if (wg) wr_addr = 22'($urandom);
      finish_burst(k % 3);
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_ready_stall();
    logic [1:0] c; logic [21:0] a; logic wg, rg; bit ok, st; int vc; exp_t e;
    apply_reset();
    rd_req = 1'b1; rd_addr = 22'h0BEEF;
    sb_q.push_back('{CMD_READ, 22'h0BEEF});
    serve(10, c, a, wg, rg, ok, st, vc);
    rd_req = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (!ok || c !== e.cmd || a !== e.addr || rg !== 1'b1 || wg !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_cmd: ok=%0b cmd=%0d addr=%h rg=%0b wg=%0b, want cmd=%0d addr=%h rg=1 wg=0",
               ok, c, a, rg, wg, e.cmd, e.addr);
    end
    vectors++;
    if (!st) begin
      miscompares++;
      $display("FAIL stall_stable: got unstable command or early grant, want stable for 10 cycles");
    end
    finish_burst(0);
  endtask

  task automatic test_done_timeout();
    logic [1:0] c; logic [21:0] a; logic wg, rg; bit ok, st; int vc;
    apply_reset();
    wr_req = 1'b1; wr_addr = 22'h12345;
    serve(0, c, a, wg, rg, ok, st, vc);
    wr_req = 1'b0;
    vectors++;
    if (!ok || c !== CMD_WRITE || a !== 22'h12345 || wg !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_write: ok=%0b cmd=%0d addr=%h wg=%0b, want cmd=1 addr=12345 wg=1", ok, c, a, wg);
    end
    wait_cyc(391);
    vectors++;
    if (ctl_if.ctl_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_hold: valid=%0b busy=%0b, want 0 1", ctl_if.ctl_valid, busy);
    end
    wait_cyc(779);
    vectors++;
    if (ref_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_early: got %0b at cycle %0d, want 0", ref_overrun, cyc);
    end
    wait_cyc(780);
    vectors++;
    if (ref_overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: got %0b at cycle %0d, want 1", ref_overrun, cyc);
    end
`ifdef ARB_WDOG_EN
    wait_cyc(1001);
    vectors++;
    if (wdog_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wdog_early: err=%0b busy=%0b, want 0 1", wdog_err, busy);
    end
    wait_cyc(1002);
    vectors++;
    if (wdog_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wdog_fire: err=%0b busy=%0b, want 1 0", wdog_err, busy);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] c; logic [21:0] a; logic wg, rg; bit ok, st; int vc;
    logic [27:0] got;
    rst = 1'b1;
    @(negedge clk);
    got = {ctl_if.ctl_valid, ctl_if.ctl_cmd, ctl_if.ctl_addr, wr_gnt, rd_gnt, busy, ref_overrun};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h, want 0", got);
    end
`ifdef ARB_WDOG_EN
    vectors++;
    if (wdog_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_wdog: got %0b, want 0", wdog_err);
    end
`endif
    rst = 1'b0;
    serve(0, c, a, wg, rg, ok, st, vc);
    vectors++;
    if (!ok || c !== CMD_REFRESH || a !== '0 || vc != 391) begin
      miscompares++;
      $display("FAIL post_reset_refresh: ok=%0b cmd=%0d addr=%h cyc=%0d, want cmd=3 addr=0 cyc=391", ok, c, a, vc);
    end
    finish_burst(1);
  endtask

  initial begin
    test_reset();
    test_refresh_period();
    test_rd_wr_order();
    test_skip_fairness();
    test_ready_stall();
    test_done_timeout();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
